// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero flagged on dz.
module seq_divider #(
    parameter int DW = 7,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quo,
    output logic [VW-1:0] rem,
    output logic          busy,
    output logic          done,
    output logic          dz
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_d;
    logic [VW-1:0] r_v;
    logic [VW:0]   r_p;
    logic [DW-2:0] r_q;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quo;
    logic [VW-1:0] r_rem;
    logic          r_busy;
    logic          r_done;
    logic          r_dz;

    logic [VW+1:0] w_t;
    logic [VW+1:0] w_diff;
    logic          w_ge;
    logic [VW:0]   w_pn;
    logic [DW-1:0] w_qn;
    logic          w_last;

    // Borrow out of the trial subtract decides the quotient bit.
    assign w_t    = {r_p, r_d[DW-1]};
    assign w_diff = w_t - {2'b00, r_v};
    assign w_ge   = ~w_diff[VW+1];
    assign w_pn   = w_ge ? w_diff[VW:0] : w_t[VW:0];
    assign w_qn   = {r_q, w_ge};
    assign w_last = (r_cnt == CW'(DW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_v     <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_d     <= dividend;
                        r_v     <= divisor;
                        r_p     <= '0;
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (r_v == '0) begin
                        r_quo   <= '1;
                        r_rem   <= '0;
                        r_dz    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_p   <= w_pn;
                        r_q   <= w_qn[DW-2:0];
                        r_d   <= {r_d[DW-2:0], 1'b0};
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quo   <= w_qn;
                            r_rem   <= w_pn[VW-1:0];
                            r_dz    <= 1'b0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign quo  = r_quo;
    assign rem  = r_rem;
    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep bench for seq_divider with hand-computed results.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] dividend;
    logic [2:0] divisor;
    logic [6:0] quo;
    logic [2:0] rem;
    logic       busy;
    logic       done;
    logic       dz;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.DW(7), .VW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quo      (quo),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drives start for exactly one rising edge; returns 1 ns after it.
    task automatic start_op(input int a, input int b);
        @(negedge clk);
        dividend = 7'(a);
        divisor  = 3'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done; lat stays 0 if the bound expires.
    task automatic wait_done(input int off, output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = off + n;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input int a, input int b,
                       input int eq, input int er, input int edz,
                       input int elat);
        int lat;
        start_op(a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done(0, lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_quo"}, quo, eq);
        check({tag, "_rem"}, rem, er);
        check({tag, "_dz"}, dz, edz);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int lat;
        int seen;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check("rst_quo", quo, 0);
        check("rst_rem", rem, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("b105_7", 105, 7, 15, 0, 0, 7);
        run("b100_7", 100, 7, 14, 2, 0, 7);
        run("b127_1", 127, 1, 127, 0, 0, 7);
        run("b5_6", 5, 6, 0, 5, 0, 7);
        run("b0_3", 0, 3, 0, 0, 0, 7);
        run("dz42", 42, 0, 127, 0, 1, 1);
        run("a42_6", 42, 6, 7, 0, 0, 7);

        // start raised at cycle 3 and held into the DONE cycle
        start_op(90, 7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 7'd20;
        divisor  = 3'd3;
        start    = 1'b1;
        wait_done(2, lat);
        check("ign_lat", lat, 7);
        check("ign_quo", quo, 12);
        check("ign_rem", rem, 6);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        check("b2b_hold", quo, 12);
        wait_done(0, lat);
        check("b2b_lat", lat, 7);
        check("b2b_quo", quo, 6);
        check("b2b_rem", rem, 2);
        @(posedge clk);
        #1;

        // asynchronous abort between edges
        start_op(77, 7);
        repeat (4) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quo", quo, 0);
        check("abort_rem", rem, 0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        run("re77_7", 77, 7, 11, 0, 0, 7);

        for (int a = 0; a < 128; a++) begin
            for (int b = 1; b < 8; b++) begin
                run($sformatf("sw%0d_%0d", a, b), a, b, a / b, a % b, 0, 7);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
